// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC owner, single-outstanding req/gnt/rvalid fetch, small decode buffer.
// Optional stall counter output enabled by defining FETCH_PERF_CNT_EN.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] Instruction_bus_o,
    output logic [6:0]  op_o,
    output logic [31:0] pc_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt_o
`endif
);

    localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned OW = CW + 1;

    typedef enum logic [1:0] {ISSUE, WAIT, DRAIN} state_e;

    state_e         state_q, state_d;
    logic [31:0]    pc_q, pc_d;
    logic [31:0]    inflight_pc_q, inflight_pc_d;
    logic [PW-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]  count_q;
    logic [31:0]    buf_word_q [BUF_DEPTH];
    logic [31:0]    buf_pc_q   [BUF_DEPTH];
    logic [31:0]    hold_instr_q, hold_pc_q;

    logic           pop, push, flush, space, req_raw;
    logic [OW-1:0]  occ;
    logic           unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc_i[1:0];

    assign instr_valid_o     = (count_q != '0);
    assign pop               = instr_valid_o && instr_ready_i;
    // A granted word still in flight already owns a buffer slot.
    assign occ               = OW'(count_q) + OW'(state_q == WAIT) - OW'(pop);
    assign space             = (occ < OW'(BUF_DEPTH));
    assign mem_req_o         = req_raw && !reset;
    assign mem_addr_o        = pc_q;
    assign Instruction_bus_o = instr_valid_o ? buf_word_q[rd_ptr_q] : hold_instr_q;
    assign pc_o              = instr_valid_o ? buf_pc_q[rd_ptr_q]   : hold_pc_q;
    assign op_o              = Instruction_bus_o[6:0];

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        req_raw       = 1'b0;
        push          = 1'b0;
        flush         = 1'b0;
        if (redirect_i) begin
            flush = 1'b1;
            pc_d  = {redirect_pc_i[31:2], 2'b00};
            state_d = ((state_q != ISSUE) && !mem_rvalid_i) ? DRAIN : ISSUE;
        end else begin
            case (state_q)
                ISSUE: begin
                    req_raw = space;
                    if (space && mem_gnt_i) begin
                        state_d       = WAIT;
                        pc_d          = pc_q + 32'd4;
                        inflight_pc_d = pc_q;
                    end
                end
                WAIT: begin
                    if (mem_rvalid_i) begin
                        push    = 1'b1;
                        req_raw = space;
                        if (space && mem_gnt_i) begin
                            pc_d          = pc_q + 32'd4;
                            inflight_pc_d = pc_q;
                        end else begin
                            state_d = ISSUE;
                        end
                    end
                end
                DRAIN: begin
                    if (mem_rvalid_i) state_d = ISSUE;
                end
                default: state_d = ISSUE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ISSUE;
            pc_q          <= RESET_PC;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                buf_word_q[i] <= '0;
                buf_pc_q[i]   <= '0;
            end
        end else begin
            hold_instr_q <= Instruction_bus_o;
            hold_pc_q    <= pc_o;
            if (flush) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    buf_word_q[wr_ptr_q] <= mem_rdata_i;
                    buf_pc_q[wr_ptr_q]   <= inflight_pc_q;
                    wr_ptr_q             <= wr_ptr_q + PW'(1);
                end
                if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (!instr_valid_o && instr_ready_i && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: queue-based reference model, random memory/decode stimulus,
// and directed sequences pinning reset, throughput, back-pressure, redirect and wrap behaviour.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RPC   = 32'h0040_0000;
    localparam int          DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req_o, mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
    logic [31:0] mem_addr_o, mem_rdata_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        instr_valid_o, instr_ready_i = 1'b0;
    logic [31:0] Instruction_bus_o, pc_o;
    logic [6:0]  op_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_o;
`endif

    always #5 clk = ~clk;

    instruction_fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .mem_req_o        (mem_req_o),
        .mem_addr_o       (mem_addr_o),
        .mem_gnt_i        (mem_gnt_i),
        .mem_rvalid_i     (mem_rvalid_i),
        .mem_rdata_i      (mem_rdata_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .instr_valid_o    (instr_valid_o),
        .instr_ready_i    (instr_ready_i),
        .Instruction_bus_o(Instruction_bus_o),
        .op_o             (op_o),
        .pc_o             (pc_o)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt_o      (stall_cnt_o)
`endif
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] w;
    } ent_t;

    int checks = 0;
    int errors = 0;

    // reference model: decode-side queue, expected fetch PC, one memory transaction in flight
    ent_t        q[$];
    logic [31:0] next_pc = RPC;
    logic [31:0] last_w = '0, last_a = '0;
    bit          out_b = 0, disc_b = 0;
    logic [31:0] out_addr = '0;
    int          delay = 0;
    longint      exp_stall = 0;

    // stimulus knobs for the next cycle
    bit          rst_v = 1, ready_v = 0, redir_v = 0, gnt_v = 0;
    logic [31:0] redir_pc_v = '0;
    int          lat_v = 0;

    // values sampled in the last cycle
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_instr;

    function automatic logic [31:0] mword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        bit   rv, pop, has, exp_req;
        int   occ;
        ent_t e;
        @(posedge clk);
        #1;
        reset         = rst_v;
        instr_ready_i = ready_v;
        redirect_i    = redir_v;
        redirect_pc_i = redir_pc_v;
        mem_gnt_i     = gnt_v;
        rv = 0;
        if (!rst_v && out_b) begin
            if (delay == 0) rv = 1;
            else delay--;
        end
        mem_rvalid_i = rv;
        mem_rdata_i  = rv ? mword(out_addr) : $urandom;
        @(negedge clk);
        s_req = mem_req_o; s_valid = instr_valid_o; s_addr = mem_addr_o;
        s_pc = pc_o; s_instr = Instruction_bus_o;
        if (rst_v) begin
            chk("rst_req", {31'd0, mem_req_o}, 32'd0);
            chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
            chk("rst_instr", Instruction_bus_o, 32'd0);
            chk("rst_pc", pc_o, 32'd0);
            chk("rst_op", {25'd0, op_o}, 32'd0);
            q.delete();
            next_pc = RPC; last_w = '0; last_a = '0;
            out_b = 0; disc_b = 0; delay = 0; exp_stall = 0;
`ifdef FETCH_PERF_CNT_EN
            chk("rst_stall", stall_cnt_o, 32'd0);
`endif
            return;
        end
        has     = (q.size() != 0);
        pop     = has && ready_v;
        occ     = q.size() + ((out_b && !disc_b) ? 1 : 0) - (pop ? 1 : 0);
        exp_req = !redir_v && (!out_b || (rv && !disc_b)) && (occ < DEPTH);
        chk("req", {31'd0, mem_req_o}, {31'd0, exp_req});
        chk("valid", {31'd0, instr_valid_o}, {31'd0, has});
        if (has) begin
            last_w = q[0].w;
            last_a = q[0].a;
        end
        chk("instr", Instruction_bus_o, last_w);
        chk("pc", pc_o, last_a);
        chk("op", {25'd0, op_o}, {25'd0, last_w[6:0]});
        if (exp_req) chk("addr", mem_addr_o, next_pc);
`ifdef FETCH_PERF_CNT_EN
        chk("stall", stall_cnt_o, exp_stall[31:0]);
`endif
        if (!has && ready_v && exp_stall != 64'hFFFF_FFFF) exp_stall++;
        if (redir_v) begin
            q.delete();
            next_pc = redir_pc_v & 32'hFFFF_FFFC;
            if (out_b && !rv) disc_b = 1;
            else begin
                out_b = 0;
                disc_b = 0;
            end
        end else begin
            if (pop) void'(q.pop_front());
            if (rv) begin
                if (!disc_b) begin
                    e.a = out_addr;
                    e.w = mword(out_addr);
                    q.push_back(e);
                end
                out_b = 0;
                disc_b = 0;
            end
            if (exp_req && gnt_v) begin
                out_b = 1;
                out_addr = next_pc;
                delay = lat_v;
                next_pc = next_pc + 32'd4;
            end
        end
    endtask

    task automatic do_reset();
        rst_v = 1; redir_v = 0; ready_v = 1; gnt_v = 1; lat_v = 0;
        repeat (2) cycle();
        rst_v = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // zero-wait memory, decode always ready: one instruction per cycle from c2
        do_reset();
        cycle(); chk("c0_valid", {31'd0, s_valid}, 32'd0);
        cycle(); chk("c1_valid", {31'd0, s_valid}, 32'd0);
        cycle(); chk("c2_pc", s_pc, 32'h0040_0000); chk("c2_valid", {31'd0, s_valid}, 32'd1);
        cycle(); chk("c3_pc", s_pc, 32'h0040_0004);
        cycle(); chk("c4_pc", s_pc, 32'h0040_0008);

        // back-pressure: buffer fills, requests stop, then drains in order
        ready_v = 0;
        repeat (5) cycle();
        chk("full_req", {31'd0, s_req}, 32'd0);
        chk("full_valid", {31'd0, s_valid}, 32'd1);
        ready_v = 1;
        repeat (6) cycle();

        // redirect in the cycle the 0x00400008 word returns
        do_reset();
        repeat (3) cycle();
        redir_v = 1; redir_pc_v = 32'h0040_0100;
        cycle();
        redir_v = 0;
        cycle();
        chk("rd_valid", {31'd0, s_valid}, 32'd0);
        chk("rd_req", {31'd0, s_req}, 32'd1);
        chk("rd_addr", s_addr, 32'h0040_0100);
        cycle();
        cycle(); chk("rd_pc", s_pc, 32'h0040_0100);

        // redirect while a granted request waits 3 extra cycles for rvalid
        do_reset();
        lat_v = 3;
        cycle();
        redir_v = 1; redir_pc_v = 32'h0040_0101;
        cycle();
        redir_v = 0;
        cycle();
        cycle(); chk("drain_req", {31'd0, s_req}, 32'd0);
        cycle(); chk("drain_rv_req", {31'd0, s_req}, 32'd0);
        cycle(); chk("drain_addr", s_addr, 32'h0040_0100); chk("drain_req2", {31'd0, s_req}, 32'd1);
        lat_v = 0;
        repeat (8) cycle();

        // grant withheld for 4 cycles: request and address hold
        do_reset();
        gnt_v = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("hold_req", {31'd0, s_req}, 32'd1);
            chk("hold_addr", s_addr, RPC);
        end
        gnt_v = 1;
        repeat (4) cycle();

        // address wrap past 0xFFFFFFFC
        do_reset();
        redir_v = 1; redir_pc_v = 32'hFFFF_FFFF;
        cycle();
        redir_v = 0;
        cycle(); chk("wrap_a0", s_addr, 32'hFFFF_FFFC);
        cycle(); chk("wrap_a1", s_addr, 32'h0000_0000);
        cycle(); chk("wrap_pc", s_pc, 32'hFFFF_FFFC);
        repeat (3) cycle();

`ifdef FETCH_PERF_CNT_EN
        // ready held, rvalid 3 cycles late: counter starts at 0 and counts empty cycles
        do_reset();
        lat_v = 3;
        cycle(); chk("perf_c0", stall_cnt_o, 32'd0);
        repeat (5) cycle();
        chk("perf_c5", stall_cnt_o, 32'd5);
        lat_v = 0;
`endif

        // randomized traffic, redirects and occasional reset
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rst_v      = ($urandom_range(0, 499) == 0);
            ready_v    = ($urandom_range(0, 3) != 0);
            gnt_v      = ($urandom_range(0, 9) < 6);
            lat_v      = $urandom_range(0, 3);
            redir_v    = ($urandom_range(0, 15) == 0);
            redir_pc_v = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
